multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/core_pkg.sv | 23 ++
 rtl/core_regfile.sv | 30 +++
 rtl/multicycle_core.sv | 121 ++++++++++++
 tb/tb_multicycle_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared FSM states, RV64I decode constants and ALU operation encoding
package core_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;
endpackage

// File: rtl/core_regfile.sv
// core_regfile: two async read ports, one sync write port, x0 hardwired to zero
module core_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  function automatic logic [AW-1:0] idx(input logic [4:0] f);
    return AW'({1'b0, f} % 6'(NREGS));
  endfunction
  assign rd1 = idx(ra1) == '0 ? '0 : regs[idx(ra1)];
  assign rd2 = idx(ra2) == '0 ? '0 : regs[idx(ra2)];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && idx(wa) != '0) begin
      regs[idx(wa)] <= wd;
    end
  end
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB RV64I subset core with a single memory port
module multicycle_core
  import core_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            zero,
  output logic            halted
);
  state_t          state;
  logic            gap;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, imm, aluout, mdr, rd1, rd2, op2, alu_res, imm_next, pc_next4;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            is_r, is_addi, is_ld, is_sd, is_beq, valid, done;
  alu_op_t         alu_op;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign is_r    = opcode == OP_R && ((funct3 == F3_ADD && (funct7 == F7_BASE || funct7 == F7_SUB)) ||
                   ((funct3 == F3_AND || funct3 == F3_OR) && funct7 == F7_BASE));
  assign is_addi = opcode == OP_IMM && funct3 == F3_ADD;
  assign is_ld   = opcode == OP_LD && funct3 == F3_D;
  assign is_sd   = opcode == OP_ST && funct3 == F3_D;
  assign is_beq  = opcode == OP_BR && funct3 == F3_BEQ;
  assign valid   = is_r || is_addi || is_ld || is_sd || is_beq;

  assign imm_next = is_sd  ? XLEN'($signed({ir[31:25], ir[11:7]})) :
                    is_beq ? XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0})) :
                             XLEN'($signed(ir[31:20]));

  assign alu_op  = is_beq ? ALU_SUB :
                   !is_r  ? ALU_ADD :
                   funct3 == F3_AND ? ALU_AND :
                   funct3 == F3_OR  ? ALU_OR  :
                   funct7 == F7_SUB ? ALU_SUB : ALU_ADD;
  assign op2     = (is_r || is_beq) ? b : imm;
  assign alu_res = alu_op == ALU_SUB ? a - op2 :
                   alu_op == ALU_AND ? a & op2 :
                   alu_op == ALU_OR  ? a | op2 : a + op2;
  assign pc_next4 = pc + XLEN'(4);

  // gap keeps mem_req low for one cycle after reset and after a store completes
  assign mem_req   = (state == S_FETCH && !gap) || state == S_MEM;
  assign mem_we    = state == S_MEM && is_sd;
  assign mem_addr  = state == S_MEM ? aluout : pc;
  assign mem_wdata = b;
  assign done      = mem_req && mem_ready;
  assign halted    = state == S_HALT;

  core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[19:15]),
    .ra2 (ir[24:20]),
    .wa  (ir[11:7]),
    .we  (state == S_WB),
    .wd  (is_ld ? mdr : aluout),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      gap    <= 1'b1;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      aluout <= '0;
      mdr    <= '0;
      zero   <= 1'b0;
    end else begin
      gap <= 1'b0;
      case (state)
        S_FETCH: if (done) begin
          ir    <= mem_rdata[31:0];
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= rd1;
          b     <= rd2;
          imm   <= imm_next;
          state <= valid ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          aluout <= alu_res;
          zero   <= alu_res == '0;
          if (is_beq) pc <= alu_res == '0 ? pc + imm : pc_next4;
          state  <= is_beq ? S_FETCH : (is_ld || is_sd) ? S_MEM : S_WB;
        end
        S_MEM: if (done) begin
          if (is_ld) mdr <= mem_rdata;
          if (is_sd) pc <= pc_next4;
          gap   <= is_sd;
          state <= is_sd ? S_FETCH : S_WB;
        end
        S_WB: begin
          pc    <= pc_next4;
          state <= S_FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed program checks for multicycle_core
module tb_multicycle_core;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, zero, halted;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [63:0] mem [0:1023];
  logic        manual = 1'b0, man_ready = 1'b0;
  logic [63:0] dly_addr = '1;
  int          dly_n = 0, cnt = 0, st_cnt = 0;
  logic [63:0] st_addr = '0, st_data = '0;
  int          n_checks = 0, n_fail = 0;

  multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h100)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .zero      (zero),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = manual ? man_ready : (mem_req && (mem_addr != dly_addr || cnt >= dly_n));

  always @(posedge clk) cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [63:0] target, input int maxc, output int n);
    n = 0;
    while (pc !== target && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic load_program;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[64] = 64'(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
    mem[65] = 64'(enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'h13));
    mem[66] = 64'(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    mem[67] = 64'(enc_s(12'd0, 5'd3, 5'd0));
    mem[68] = 64'(enc_i(12'd8, 5'd0, 3'b011, 5'd4, 7'h03));
    mem[69] = 64'(enc_s(12'd16, 5'd4, 5'd0));
    mem[70] = 64'(enc_b(13'h1F08, 5'd0, 5'd0));
    mem[8]  = 64'(enc_b(13'd16, 5'd1, 5'd1));
    mem[9]  = 64'(enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13));
    mem[10] = 64'(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5));
    mem[11] = 64'(enc_s(12'd24, 5'd5, 5'd0));
    mem[12] = 64'(enc_b(13'd16, 5'd0, 5'd0));
    mem[16] = 64'(enc_b(13'h1FE0, 5'd0, 5'd0));
    mem[2]  = 64'hDEAD;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (pc !== 64'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h100); end
    n_checks++; if ({mem_req, halted, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: req/halt/zero got %b expected 000", {mem_req, halted, zero}); end
    rst = 1'b0;
    tick();
    n_checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 64'h100}) begin n_fail++; $display("FAIL first_fetch: req=%b we=%b addr=%h expected 1 0 100", mem_req, mem_we, mem_addr); end
  endtask

  task automatic test_alu_store;
    int n;
    wait_pc(64'h104, 20, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL addi1_cycles: got %0d expected 4", n); end
    wait_pc(64'h108, 20, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL addi2_cycles: got %0d expected 4", n); end
    wait_pc(64'h10C, 20, n);
    n_checks++; if (n !== 4 || zero !== 1'b0) begin n_fail++; $display("FAIL add_cycles_zero: got %0d/%b expected 4/0", n, zero); end
    wait_pc(64'h110, 20, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL sd_cycles: got %0d expected 4", n); end
    n_checks++; if ({st_cnt, st_addr, st_data} !== {32'd1, 64'h0, 64'd12}) begin n_fail++; $display("FAIL sd_store: cnt=%0d addr=%h data=%h expected 1 0 c", st_cnt, st_addr, st_data); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sd_zero: got %b expected 1", zero); end
  endtask

  task automatic test_load_wait;
    int n, m, w;
    dly_addr = 64'h8;
    dly_n = 3;
    w = 0;
    while (!mem_req && w < 5) begin tick(); w++; end
    n = 0;
    while (!(mem_req && mem_addr == 64'h8) && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({mem_req, mem_we, mem_ready, mem_addr} !== {3'b100, 64'h8}) begin n_fail++; $display("FAIL ld_wait_stable: req=%b we=%b rdy=%b addr=%h expected 1 0 0 8", mem_req, mem_we, mem_ready, mem_addr); end
      tick();
      n++;
    end
    wait_pc(64'h114, 20, m);
    n_checks++; if (n + m !== 8) begin n_fail++; $display("FAIL ld_cycles: got %0d expected 8", n + m); end
    dly_addr = '1;
    wait_pc(64'h118, 20, n);
    n_checks++; if ({st_cnt, st_addr, st_data} !== {32'd2, 64'h10, 64'hDEAD}) begin n_fail++; $display("FAIL ld_value: cnt=%0d addr=%h data=%h expected 2 10 dead", st_cnt, st_addr, st_data); end
  endtask

  task automatic test_branch;
    int n;
    wait_pc(64'h20, 20, n);
    // one extra cycle: the fetch after a store waits out the request gap
    n_checks++; if (n !== 4 || zero !== 1'b1) begin n_fail++; $display("FAIL beq_back: cycles/zero got %0d/%b expected 4/1", n, zero); end
    wait_pc(64'h30, 20, n);
    n_checks++; if (n !== 3 || zero !== 1'b1) begin n_fail++; $display("FAIL beq_taken: cycles/zero got %0d/%b expected 3/1", n, zero); end
    mem[8] = 64'(enc_b(13'd16, 5'd2, 5'd1));
    wait_pc(64'h40, 20, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL beq_fwd: got %0d expected 3", n); end
    mem[12] = '0;
    wait_pc(64'h20, 20, n);
    wait_pc(64'h24, 20, n);
    n_checks++; if (n !== 3 || zero !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: cycles/zero got %0d/%b expected 3/0", n, zero); end
  endtask

  task automatic test_x0_halt;
    int n;
    wait_pc(64'h28, 20, n);
    wait_pc(64'h2C, 20, n);
    n_checks++; if (n !== 4 || zero !== 1'b1) begin n_fail++; $display("FAIL add_x0: cycles/zero got %0d/%b expected 4/1", n, zero); end
    wait_pc(64'h30, 20, n);
    n_checks++; if ({st_cnt, st_addr, st_data} !== {32'd3, 64'h18, 64'h0}) begin n_fail++; $display("FAIL x0_store: cnt=%0d addr=%h data=%h expected 3 18 0", st_cnt, st_addr, st_data); end
    wait_halt(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL halt_cycles: got %0d expected 3", n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if ({halted, mem_req, pc} !== {2'b10, 64'h30}) begin n_fail++; $display("FAIL halt_hold: halted=%b req=%b pc=%h expected 1 0 30", halted, mem_req, pc); end
    end
  endtask

  task automatic test_reset_abort;
    int n;
    mem[64] = 64'(enc_i(12'd8, 5'd0, 3'b011, 5'd4, 7'h03));
    mem[65] = '0;
    dly_addr = 64'h8;
    dly_n = 1000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 64'h8) && n < 20) begin tick(); n++; end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL abort_reach_mem: got %0d expected 4", n); end
    tick();
    mem[64] = 64'(enc_s(12'd32, 5'd4, 5'd0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    manual = 1'b1;
    man_ready = 1'b1;
    n_checks++; if ({mem_req, halted, zero, pc} !== {3'b000, 64'h100}) begin n_fail++; $display("FAIL abort_reset: req=%b halt=%b zero=%b pc=%h expected 0 0 0 100", mem_req, halted, zero, pc); end
    tick();
    manual = 1'b0;
    man_ready = 1'b0;
    n_checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 64'h100}) begin n_fail++; $display("FAIL abort_refetch: req=%b we=%b addr=%h expected 1 0 100", mem_req, mem_we, mem_addr); end
    wait_pc(64'h104, 20, n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL abort_sd_cycles: got %0d expected 4", n); end
    n_checks++; if ({st_cnt, st_addr, st_data} !== {32'd4, 64'h20, 64'h0}) begin n_fail++; $display("FAIL abort_no_write: cnt=%0d addr=%h data=%h expected 4 20 0", st_cnt, st_addr, st_data); end
    wait_halt(n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL abort_halt: got %0d expected 3", n); end
  endtask

  initial begin
    load_program();
    test_reset();
    test_alu_store();
    test_load_wait();
    test_branch();
    test_x0_halt();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
